// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt sequencer for the pipelined 8-bit core.
// Latches request lines, applies an enable mask and fixed priority (bit 0
// highest), freezes fetch while EX/DM/WB drain, then redirects the PC to a
// per-line vector. A retired return-from-interrupt restores the saved PC.
// Optional feature: define IRQ_EDGE_EN for rising-edge request capture
// (a held-high line requests once); otherwise requests are level captured.
module irq_sequencer #(
  parameter int                NUM_IRQ      = 4,
  parameter int                ADDR_W       = 8,
  parameter int                DRAIN_CYCLES = 3,
  parameter logic [ADDR_W-1:0] VEC_BASE     = 8'hF0,
  parameter int                VEC_STRIDE   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               en_wr,
  input  logic [NUM_IRQ-1:0] en_data,
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic               reti,
  output logic               stall,
  output logic               flush,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_addr,
  output logic               irq_active,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [ADDR_W-1:0]  epc
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_VECTOR,
    S_SERVICE,
    S_RETURN
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_IRQ-1:0] en_reg;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_IRQ-1:0] capture;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [2:0]         winner;
  logic [ADDR_W-1:0]  vec_addr;
  logic               stall_d;
  logic               flush_d;
  logic               pc_load_d;
  logic               irq_active_d;
  logic [ADDR_W-1:0]  pc_load_addr_d;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;

  // Previous-cycle copy of the request lines for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_in;
    end
  end

  // A line requests only on a 0->1 transition
  always_comb begin
    capture = irq_in & ~irq_q;
  end
`else
  // A line requests whenever it is high
  always_comb begin
    capture = irq_in;
  end
`endif

  // Eligible requests, fixed-priority winner and its vector address
  always_comb begin
    eligible = pending & en_reg;
    winner   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
    vec_addr = ADDR_W'(32'(VEC_BASE) + 32'(irq_id) * 32'(VEC_STRIDE));
  end

  // Request latch update; the VECTOR-cycle clear beats a same-cycle set
  always_comb begin
    pending_nxt = pending | capture;
    if (state == S_VECTOR) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (irq_id == 3'(i)) pending_nxt[i] = 1'b0;
      end
    end
  end

  // Next-state selection; RETURN always passes through IDLE before re-acceptance
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|eligible) state_nxt = S_DRAIN;
      S_DRAIN:   if (cnt == CNT_LAST) state_nxt = S_VECTOR;
      S_VECTOR:  state_nxt = S_SERVICE;
      S_SERVICE: if (reti) state_nxt = S_RETURN;
      S_RETURN:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so outputs leave the flops aligned with it
  always_comb begin
    stall_d        = 1'b0;
    flush_d        = 1'b0;
    pc_load_d      = 1'b0;
    irq_active_d   = 1'b0;
    pc_load_addr_d = '0;
    case (state_nxt)
      S_DRAIN: stall_d = 1'b1;
      S_VECTOR: begin
        stall_d        = 1'b1;
        flush_d        = 1'b1;
        pc_load_d      = 1'b1;
        irq_active_d   = 1'b1;
        pc_load_addr_d = vec_addr;
      end
      S_SERVICE: irq_active_d = 1'b1;
      S_RETURN: begin
        flush_d        = 1'b1;
        pc_load_d      = 1'b1;
        irq_active_d   = 1'b1;
        pc_load_addr_d = epc;
      end
      default: ;
    endcase
  end

  // Sequencer state, request latch, mask, saved context and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pending      <= '0;
      en_reg       <= '0;
      epc          <= '0;
      irq_id       <= '0;
      cnt          <= '0;
      stall        <= 1'b0;
      flush        <= 1'b0;
      pc_load      <= 1'b0;
      irq_active   <= 1'b0;
      pc_load_addr <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (en_wr) en_reg <= en_data;
      if (state == S_IDLE && |eligible) begin
        irq_id <= winner;
        epc    <= cur_addr;
        cnt    <= '0;
      end else if (state == S_DRAIN && cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
      stall        <= stall_d;
      flush        <= flush_d;
      pc_load      <= pc_load_d;
      irq_active   <= irq_active_d;
      pc_load_addr <= pc_load_addr_d;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed, table-driven bench for irq_sequencer with
// default parameters, plus hand-written multi-cycle sequences for
// same-cycle reti/request, reset during drain and held-high request lines.
module tb_irq_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       en_wr;
  logic [3:0] en_data;
  logic [7:0] cur_addr;
  logic       reti;
  logic       stall;
  logic       flush;
  logic       pc_load;
  logic [7:0] pc_load_addr;
  logic       irq_active;
  logic [2:0] irq_id;
  logic [3:0] pending;
  logic [7:0] epc;

  int tests;
  int failures;
  int accepts;
  int expAccepts;

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       enw;
    logic [3:0] en;
    logic [7:0] cur;
    logic       ret;
    logic       st;
    logic       fl;
    logic       pl;
    logic [7:0] addr;
    logic       act;
    logic [2:0] id;
    logic [3:0] pend;
    logic [7:0] epcv;
  } vec_t;

  vec_t vecs[27];

  irq_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .en_wr        (en_wr),
    .en_data      (en_data),
    .cur_addr     (cur_addr),
    .reti         (reti),
    .stall        (stall),
    .flush        (flush),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .irq_active   (irq_active),
    .irq_id       (irq_id),
    .pending      (pending),
    .epc          (epc)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rst, input int irq, input int enw, input int en,
                              input int cur, input int ret, input int st, input int fl,
                              input int pl, input int addr, input int act, input int id,
                              input int pend, input int epcv);
    vec_t v;
    v.rst  = 1'(rst);
    v.irq  = 4'(irq);
    v.enw  = 1'(enw);
    v.en   = 4'(en);
    v.cur  = 8'(cur);
    v.ret  = 1'(ret);
    v.st   = 1'(st);
    v.fl   = 1'(fl);
    v.pl   = 1'(pl);
    v.addr = 8'(addr);
    v.act  = 1'(act);
    v.id   = 3'(id);
    v.pend = 4'(pend);
    v.epcv = 8'(epcv);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    irq_in   = v.irq;
    en_wr    = v.enw;
    en_data  = v.en;
    cur_addr = v.cur;
    reti     = v.ret;
    tick();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue($sformatf("v%0d.stall", idx), 8'(stall), 8'(v.st));
    checkValue($sformatf("v%0d.flush", idx), 8'(flush), 8'(v.fl));
    checkValue($sformatf("v%0d.pc_load", idx), 8'(pc_load), 8'(v.pl));
    checkValue($sformatf("v%0d.pc_load_addr", idx), pc_load_addr, v.addr);
    checkValue($sformatf("v%0d.irq_active", idx), 8'(irq_active), 8'(v.act));
    checkValue($sformatf("v%0d.irq_id", idx), 8'(irq_id), 8'(v.id));
    checkValue($sformatf("v%0d.pending", idx), 8'(pending), 8'(v.pend));
    checkValue($sformatf("v%0d.epc", idx), epc, v.epcv);
  endtask

  task automatic idleInputs();
    reset    = 1'b0;
    irq_in   = 4'h0;
    en_wr    = 1'b0;
    en_data  = 4'h0;
    reti     = 1'b0;
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset    = 1'b1;
    irq_in   = 4'h0;
    en_wr    = 1'b0;
    en_data  = 4'h0;
    cur_addr = 8'h00;
    reti     = 1'b0;

    //            rst irq enw en  cur   ret | st fl pl addr  act id pend epc
    vecs[0]  = mk(1, 'h0, 0, 'h0, 'h00, 0,   0, 0, 0, 'h00, 0, 0, 'h0, 'h00);
    vecs[1]  = mk(0, 'h0, 1, 'hF, 'h1A, 0,   0, 0, 0, 'h00, 0, 0, 'h0, 'h00);
    vecs[2]  = mk(0, 'h4, 0, 'h0, 'h1A, 0,   0, 0, 0, 'h00, 0, 0, 'h4, 'h00);
    vecs[3]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   1, 0, 0, 'h00, 0, 2, 'h4, 'h1A);
    vecs[4]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   1, 0, 0, 'h00, 0, 2, 'h4, 'h1A);
    vecs[5]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   1, 0, 0, 'h00, 0, 2, 'h4, 'h1A);
    vecs[6]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   1, 1, 1, 'hF8, 1, 2, 'h4, 'h1A);
    vecs[7]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   0, 0, 0, 'h00, 1, 2, 'h0, 'h1A);
    vecs[8]  = mk(0, 'h0, 0, 'h0, 'h1A, 1,   0, 1, 1, 'h1A, 1, 2, 'h0, 'h1A);
    vecs[9]  = mk(0, 'h0, 0, 'h0, 'h1A, 0,   0, 0, 0, 'h00, 0, 2, 'h0, 'h1A);
    vecs[10] = mk(0, 'h0, 1, 'hE, 'h40, 0,   0, 0, 0, 'h00, 0, 2, 'h0, 'h1A);
    vecs[11] = mk(0, 'hB, 0, 'h0, 'h40, 0,   0, 0, 0, 'h00, 0, 2, 'hB, 'h1A);
    vecs[12] = mk(0, 'h0, 0, 'h0, 'h40, 0,   1, 0, 0, 'h00, 0, 1, 'hB, 'h40);
    vecs[13] = mk(0, 'h0, 0, 'h0, 'h40, 0,   1, 0, 0, 'h00, 0, 1, 'hB, 'h40);
    vecs[14] = mk(0, 'h0, 0, 'h0, 'h40, 0,   1, 0, 0, 'h00, 0, 1, 'hB, 'h40);
    vecs[15] = mk(0, 'h0, 0, 'h0, 'h40, 0,   1, 1, 1, 'hF4, 1, 1, 'hB, 'h40);
    vecs[16] = mk(0, 'h0, 0, 'h0, 'h40, 0,   0, 0, 0, 'h00, 1, 1, 'h9, 'h40);
    vecs[17] = mk(0, 'h0, 0, 'h0, 'h40, 0,   0, 0, 0, 'h00, 1, 1, 'h9, 'h40);
    vecs[18] = mk(0, 'h0, 0, 'h0, 'h40, 1,   0, 1, 1, 'h40, 1, 1, 'h9, 'h40);
    vecs[19] = mk(0, 'h0, 0, 'h0, 'h44, 0,   0, 0, 0, 'h00, 0, 1, 'h9, 'h40);
    vecs[20] = mk(0, 'h0, 0, 'h0, 'h44, 0,   1, 0, 0, 'h00, 0, 3, 'h9, 'h44);
    vecs[21] = mk(0, 'h0, 0, 'h0, 'h44, 0,   1, 0, 0, 'h00, 0, 3, 'h9, 'h44);
    vecs[22] = mk(0, 'h0, 0, 'h0, 'h44, 0,   1, 0, 0, 'h00, 0, 3, 'h9, 'h44);
    vecs[23] = mk(0, 'h0, 0, 'h0, 'h44, 0,   1, 1, 1, 'hFC, 1, 3, 'h9, 'h44);
    vecs[24] = mk(0, 'h0, 0, 'h0, 'h44, 0,   0, 0, 0, 'h00, 1, 3, 'h1, 'h44);
    vecs[25] = mk(0, 'h0, 0, 'h0, 'h44, 1,   0, 1, 1, 'h44, 1, 3, 'h1, 'h44);
    vecs[26] = mk(0, 'h0, 0, 'h0, 'h44, 0,   0, 0, 0, 'h00, 0, 3, 'h1, 'h44);

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Request arriving together with reti: latched, not preempting
    idleInputs();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    en_wr    = 1'b1;
    en_data  = 4'hF;
    cur_addr = 8'h20;
    tick();
    en_wr  = 1'b0;
    irq_in = 4'h2;
    tick();
    irq_in = 4'h0;
    tick();
    tick();
    tick();
    tick();
    checkValue("seq.vector_pc_load", 8'(pc_load), 8'h01);
    checkValue("seq.vector_addr", pc_load_addr, 8'hF4);
    tick();
    checkValue("seq.service_active", 8'(irq_active), 8'h01);
    checkValue("seq.service_stall", 8'(stall), 8'h00);
    irq_in = 4'h1;
    reti   = 1'b1;
    tick();
    irq_in = 4'h0;
    reti   = 1'b0;
    checkValue("seq.return_pc_load", 8'(pc_load), 8'h01);
    checkValue("seq.return_addr", pc_load_addr, 8'h20);
    checkValue("seq.return_pending", 8'(pending), 8'h01);
    checkValue("seq.return_irq_id", 8'(irq_id), 8'h01);
    tick();
    checkValue("seq.idle_active", 8'(irq_active), 8'h00);
    checkValue("seq.idle_stall", 8'(stall), 8'h00);
    checkValue("seq.idle_pending", 8'(pending), 8'h01);
    tick();
    checkValue("seq.accept0_stall", 8'(stall), 8'h01);
    checkValue("seq.accept0_irq_id", 8'(irq_id), 8'h00);
    checkValue("seq.accept0_epc", epc, 8'h20);

    // Reset on the second drain cycle aborts without a PC redirect
    tick();
    checkValue("seq.drain2_stall", 8'(stall), 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkValue("rst.stall", 8'(stall), 8'h00);
    checkValue("rst.flush", 8'(flush), 8'h00);
    checkValue("rst.pc_load", 8'(pc_load), 8'h00);
    checkValue("rst.pc_load_addr", pc_load_addr, 8'h00);
    checkValue("rst.irq_active", 8'(irq_active), 8'h00);
    checkValue("rst.irq_id", 8'(irq_id), 8'h00);
    checkValue("rst.pending", 8'(pending), 8'h00);
    checkValue("rst.epc", epc, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkValue($sformatf("rst.after%0d_pc_load", i), 8'(pc_load), 8'h00);
      checkValue($sformatf("rst.after%0d_stall", i), 8'(stall), 8'h00);
    end

    // Line 0 held high for 20 cycles across one full service
    idleInputs();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    en_wr   = 1'b1;
    en_data = 4'h1;
    tick();
    en_wr   = 1'b0;
    accepts = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      irq_in = (cyc <= 20) ? 4'h1 : 4'h0;
      reti   = (cyc == 12);
      tick();
      if (pc_load && stall) accepts++;
    end
    irq_in = 4'h0;
    reti   = 1'b0;
`ifdef IRQ_EDGE_EN
    expAccepts = 1;
`else
    expAccepts = 2;
`endif
    checkValue("held.accept_count", 8'(accepts), 8'(expAccepts));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
